// File: rtl/ps2_key_event_fifo.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 pins, frames
// 11-bit PS/2 packets, decodes E0/F0 prefixes into make/break key events
// and buffers those events in a show-ahead FIFO for the CPU.
module ps2_key_event_fifo #(
  parameter int unsigned CLK_DIV       = 250,
  parameter int unsigned TIMEOUT_TICKS = 4000,
  parameter int unsigned FILTER_LEN    = 3,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                          iCLK,
  input  logic                          iRST_n,
  input  logic                          iPS2_clk,
  input  logic                          iPS2_data,
  input  logic                          iRd,
  input  logic                          iClr,
  output logic [31:0]                   oEvent,
  output logic                          oValid,
  output logic                          interrupt,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  output logic [7:0]                    oErrCnt,
  output logic                          oOverflow
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned IW = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_CHECK} frame_state_t;
  typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

  logic [1:0]    clk_s, dat_s;
  logic          clk_sync, dat_sync;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip, ps2_fall;

  frame_state_t  frame_state, frame_next;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic          frame_ok, frame_err, timeout_err;

  dec_state_t    dec_state, dec_next;
  logic          push_req, dec_err;
  logic [9:0]    push_evt;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [9:0]    hold_q, head;
  logic          full, do_push, do_pop, drop;

  assign clk_sync = clk_s[1];
  assign dat_sync = dat_s[1];

  // Two-stage synchronisers for the asynchronous PS/2 pins (idle high)
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_s <= '1;
      dat_s <= '1;
    end else begin
      clk_s <= {clk_s[0], iPS2_clk};
      dat_s <= {dat_s[0], iPS2_data};
    end
  end

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  // Sampling tick divider
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)   div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // The filter flips once the differing sample has been seen FILTER_LEN ticks
  // in a row; the falling edge is taken on that same tick so the frame FSM
  // samples data in step with the filter.
  assign filt_flip = tick && (clk_sync != filt_clk) &&
                     ((filt_cnt + FW'(1)) == FW'(FILTER_LEN));
  assign ps2_fall  = filt_flip && filt_clk;

  // Glitch filter on the synchronised PS/2 clock
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (tick) begin
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_flip) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM state register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) frame_state <= F_IDLE;
    else         frame_state <= frame_next;
  end

  // Frame FSM next state and frame-result pulses
  always_comb begin
    frame_next  = frame_state;
    frame_ok    = 1'b0;
    frame_err   = 1'b0;
    timeout_err = 1'b0;
    case (frame_state)
      F_IDLE: begin
        if (ps2_fall && !dat_sync) frame_next = F_SHIFT;
      end
      F_SHIFT: begin
        if (ps2_fall) begin
          if (bit_cnt == 4'd10) frame_next = F_CHECK;
        end else if (tick && (idle_cnt == IW'(TIMEOUT_TICKS - 1))) begin
          timeout_err = 1'b1;
          frame_next  = F_IDLE;
        end
      end
      F_CHECK: begin
        if (tick) begin
          if (shreg[9] && (^shreg[8:0])) frame_ok  = 1'b1;
          else                           frame_err = 1'b1;
          frame_next = F_IDLE;
        end
      end
      default: frame_next = F_IDLE;
    endcase
  end

  // Frame shift register, bit counter and inter-edge idle counter
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      case (frame_state)
        F_IDLE: begin
          if (ps2_fall && !dat_sync) begin
            shreg    <= '0;
            bit_cnt  <= 4'd1;
            idle_cnt <= '0;
          end
        end
        F_SHIFT: begin
          if (ps2_fall) begin
            shreg    <= {dat_sync, shreg[9:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            idle_cnt <= '0;
          end else if (tick) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Decoder FSM state register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) dec_state <= D_BASE;
    else         dec_state <= dec_next;
  end

  // Prefix decoder: E0 marks extended, F0 marks break, 00/FF are overruns
  always_comb begin
    dec_next = dec_state;
    push_req = 1'b0;
    dec_err  = 1'b0;
    push_evt = {(dec_state == D_BRK) || (dec_state == D_EXTBRK),
                (dec_state == D_EXT) || (dec_state == D_EXTBRK),
                shreg[7:0]};
    if (frame_ok) begin
      case (shreg[7:0])
        8'hE0: begin
          if (dec_state == D_BASE)     dec_next = D_EXT;
          else if (dec_state == D_BRK) dec_next = D_EXTBRK;
        end
        8'hF0: begin
          if (dec_state == D_BASE)     dec_next = D_BRK;
          else if (dec_state == D_EXT) dec_next = D_EXTBRK;
        end
        8'h00, 8'hFF: begin
          dec_err  = 1'b1;
          dec_next = D_BASE;
        end
        default: begin
          push_req = 1'b1;
          dec_next = D_BASE;
        end
      endcase
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = iRd && (count != '0);
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  // Event FIFO storage, pointers and occupancy
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_evt;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Error counter and sticky overflow; software clear has priority
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oErrCnt   <= '0;
      oOverflow <= 1'b0;
    end else if (iClr) begin
      oErrCnt   <= '0;
      oOverflow <= 1'b0;
    end else begin
      if ((frame_err || timeout_err || dec_err) && (oErrCnt != 8'hFF))
        oErrCnt <= oErrCnt + 8'd1;
      if (drop) oOverflow <= 1'b1;
    end
  end

  assign oValid    = (count != '0);
  assign interrupt = oValid;
  assign oCount    = count;
  assign head      = oValid ? mem[rd_ptr] : hold_q;
  assign oEvent    = {22'd0, head};

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Self-checking bench for ps2_key_event_fifo: bit-bangs PS/2 frames,
// keeps expected key events in a scoreboard queue and drains the FIFO.
module tb_ps2_key_event_fifo;

  localparam int HALF = 32;
  localparam int GAP  = 128;

  logic        clk = 1'b0;
  logic        rst_n, ps2c, ps2d, rd, clr;
  logic [31:0] ev;
  logic        valid, irq, ovf;
  logic [2:0]  cnt;
  logic [7:0]  errc;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         has_ev;
    logic [9:0] evt;
    logic [7:0] err;
  } vec_t;
  vec_t vecs [13];

  ps2_key_event_fifo #(
    .CLK_DIV      (4),
    .TIMEOUT_TICKS(64),
    .FILTER_LEN   (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .iCLK     (clk),
    .iRST_n   (rst_n),
    .iPS2_clk (ps2c),
    .iPS2_data(ps2d),
    .iRd      (rd),
    .iClr     (clr),
    .oEvent   (ev),
    .oValid   (valid),
    .interrupt(irq),
    .oCount   (cnt),
    .oErrCnt  (errc),
    .oOverflow(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      wait_cyc(HALF);
      ps2c = 1'b0;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
  endtask

  // Pop every stored event and compare against the scoreboard head
  task automatic drain(input string tag);
    logic [9:0] e;
    int guard = 0;
    while (valid && guard < 8) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s unexpected: got 0x%0h required none", tag, ev);
      end else begin
        check({tag, " count"}, 32'(cnt), 32'(exp_q.size()));
        e = exp_q.pop_front();
        check({tag, " event"}, ev, {22'd0, e});
        check({tag, " irq"}, 32'(irq), 32'd1);
      end
      rd = 1'b1;
      wait_cyc(1);
      rd = 1'b0;
      guard++;
    end
    check({tag, " missing"}, 32'(exp_q.size()), 32'd0);
    check({tag, " empty"}, 32'(valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    ps2c = 1'b1; ps2d = 1'b1; rd = 1'b0; clr = 1'b0; rst_n = 1'b0;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 8'd0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd0};
    vecs[2]  = '{8'h75, 1'b0, 1'b1, 10'h175, 8'd0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 10'h375, 8'd0};
    vecs[6]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 8'd1};
    vecs[7]  = '{8'h32, 1'b0, 1'b1, 10'h032, 8'd1};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd1};
    vecs[9]  = '{8'h00, 1'b0, 1'b0, 10'h000, 8'd2};
    vecs[10] = '{8'h1C, 1'b0, 1'b1, 10'h01C, 8'd2};
    vecs[11] = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd2};
    vecs[12] = '{8'h1C, 1'b0, 1'b1, 10'h21C, 8'd2};

    wait_cyc(5);
    check("rst event", ev, 32'd0);
    check("rst valid", 32'(valid), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    check("rst count", 32'(cnt), 32'd0);
    check("rst errcnt", 32'(errc), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < 13; i++) begin
      send_frame(vecs[i].code, vecs[i].bad_par, 11);
      if (vecs[i].has_ev) exp_q.push_back(vecs[i].evt);
      check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].has_ev));
      check($sformatf("vec%0d errcnt", i), 32'(errc), 32'(vecs[i].err));
      drain($sformatf("vec%0d", i));
    end

    // Partial frame followed by silence must time out
    pulse_clr();
    check("clr errcnt", 32'(errc), 32'd0);
    send_frame(8'h15, 1'b0, 6);
    wait_cyc(300);
    check("timeout errcnt", 32'(errc), 32'd1);
    check("timeout valid", 32'(valid), 32'd0);
    send_frame(8'h15, 1'b0, 11);
    exp_q.push_back(10'h015);
    drain("after timeout");

    // Fifth event with no reads overflows a 4-deep FIFO
    pulse_clr();
    send_frame(8'h16, 1'b0, 11); exp_q.push_back(10'h016);
    send_frame(8'h1E, 1'b0, 11); exp_q.push_back(10'h01E);
    send_frame(8'h26, 1'b0, 11); exp_q.push_back(10'h026);
    send_frame(8'h25, 1'b0, 11); exp_q.push_back(10'h025);
    check("pre-ovf flag", 32'(ovf), 32'd0);
    send_frame(8'h2E, 1'b0, 11);
    check("ovf count", 32'(cnt), 32'd4);
    check("ovf flag", 32'(ovf), 32'd1);
    drain("overflow");
    check("ovf sticky", 32'(ovf), 32'd1);
    pulse_clr();
    check("ovf cleared", 32'(ovf), 32'd0);

    // Reset mid-frame with a pending E0 prefix, an error and a stored event
    send_frame(8'h1C, 1'b1, 11);
    send_frame(8'h16, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    check("pre-rst errcnt", 32'(errc), 32'd1);
    check("pre-rst valid", 32'(valid), 32'd1);
    ps2d = 1'b0; wait_cyc(HALF); ps2c = 1'b0; wait_cyc(HALF); ps2c = 1'b1;
    ps2d = 1'b1; wait_cyc(HALF); ps2c = 1'b0; wait_cyc(HALF);
    rst_n = 1'b0;
    ps2c = 1'b1;
    wait_cyc(3);
    check("mid rst event", ev, 32'd0);
    check("mid rst valid", 32'(valid), 32'd0);
    check("mid rst count", 32'(cnt), 32'd0);
    check("mid rst errcnt", 32'(errc), 32'd0);
    check("mid rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    wait_cyc(GAP);
    send_frame(8'h1C, 1'b0, 11);
    exp_q.push_back(10'h01C);
    check("post rst errcnt", 32'(errc), 32'd0);
    drain("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
